booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//   Sequencer for one shared radix-4 Booth partial-product stage in the FFT butterfly path.
//   - Accepts a signed A_W x B_W multiply request and walks the multiplier MSB-first, one Booth digit at a time.
//   - Issues each 3-bit window to the external stage and accumulates Horner-style: acc = 4*acc + digit*a.
//   - Returns the full P_W-bit signed product with a done pulse.
// PARAMETERS
//   A_W  12  multiplicand width (signed); must equal stage mult_2 width
//   B_W  12  multiplier width (signed, even); number of digits ND = B_W/2
//   P_W  24  product/accumulator width; must equal stage mult_pre/mult_next width (A_W+B_W)
// PORTS
//   clk           in   1    clock
//   rst_n         in   1    reset, asynchronous, active-low
//   start         in   1    request; sampled only in IDLE
//   clr           in   1    synchronous abort: returns FSM to IDLE next edge, no done
//   a             in   A_W  signed multiplicand, captured on accepted start
//   b             in   B_W  signed multiplier, captured on accepted start
//   busy          out  1    state != IDLE
//   done          out  1    one-cycle pulse; product valid
//   product       out  P_W  signed a*b; holds until next accepted start
//   a_ovf         out  1    captured a == -2^(A_W-1); valid with done
//   err           out  1    sticky; stage failed to report rdy in CAPTURE; cleared by start or reset
//   st_en         out  1    stage enable
//   st_mult_1     out  3    Booth window {b[2k+1], b[2k], b[2k-1]}, with b[-1] = 0
//   st_mult_2     out  A_W  captured a
//   st_mult_pre   out  P_W  acc << 2, truncated to P_W
//   st_rdy        in   1    stage result valid
//   st_mult_next  in   P_W  stage result: st_mult_pre + digit*a
// BEHAVIOUR
//   Reset values: all outputs 0; internal acc = 0, k = 0, state = IDLE.
//   FSM states: IDLE -> ISSUE -> CAPTURE -> (ISSUE | DONE) -> IDLE.
//   IDLE
//     - On start: capture a and b; acc <= 0; k <= ND-1; err <= 0; a_ovf <= (a == -2^(A_W-1)); go to ISSUE.
//   ISSUE
//     - st_en = 1, combinational from state; st_mult_1, st_mult_2 and st_mult_pre driven from registers.
//     - Next state: CAPTURE.
//   CAPTURE
//     - st_en = 0. The stage registered its result at the ISSUE edge, so st_rdy = 1 here.
//     - acc <= st_mult_next.
//     - If k == 0, go to DONE; otherwise k <= k-1 and go to ISSUE.
//     - If st_rdy == 0: err <= 1, acc unchanged, go to IDLE; no done pulse.
//   DONE
//     - done = 1 and product = acc for exactly one cycle; then IDLE.
//   Latency
//     - Each digit takes 2 cycles.
//     - done is high in the cycle after the (2*ND)th edge following the start-accept edge. Default: 12 edges.
//     - Next start is accepted no earlier than the first IDLE cycle after DONE.
//   Registers and outputs
//     - product is a register, updated only on entry to DONE.
//     - st_mult_1, st_mult_2 and st_mult_pre are don't-care when st_en = 0, but drive 0 in IDLE.
//   Arithmetic
//     - Windows are taken from b MSB-first with signed Booth encoding.
//     - The final acc equals a*b exactly for all b, and for all a except -2^(A_W-1).
//     - For a = -2^(A_W-1), the stage negation overflows. The product is returned unchanged (not guaranteed); a_ovf = 1 flags it.
//   Boundary conditions
//     - start while busy is ignored, with no effect on the operation in progress.
//     - start and clr in the same cycle in IDLE: clr wins and start is dropped.
//     - clr in any state: IDLE next edge; st_en deasserts immediately; product keeps its old value.
//     - rst_n asserted mid-operation: all state and outputs go to 0 at once; no done pulse.
//     - b = 0: all digits are 0; product = 0 at normal latency.
// TESTING
//   1. a=3, b=5, start 1 cycle -> done 12 edges later; product=15; a_ovf=0; err=0.
//   2. a=-7, b=9 -> product=-63 (0xFFFFC1); busy high for 13 cycles.
//   3. a=2047, b=-2048 -> product=-4192256 (0xC00800); a=-2047, b=-2048 -> product=4192256.
//   4. start pulsed again during CAPTURE of digit 3 -> ignored; product of the first operands only; one done pulse.
//   5. rst_n low at cycle 5 of a run -> busy=0, product=0, done never pulses; fresh start of 6*7 -> 42.
//   6. a=-2048, b=1 -> done with a_ovf=1; stage model forces st_rdy=0 in CAPTURE -> err=1, FSM IDLE, no done.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Sequencer for a shared radix-4 Booth partial-product stage: walks the multiplier
// MSB-first, one digit per ISSUE/CAPTURE pair, accumulating acc = 4*acc + digit*a.
// Returns the signed product with a one-cycle done pulse; clr aborts to IDLE at any time.
module booth_mult_seq #(
  parameter int A_W = 12,
  parameter int B_W = 12,
  parameter int P_W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           clr,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product,
  output logic           a_ovf,
  output logic           err,
  output logic           st_en,
  output logic [2:0]     st_mult_1,
  output logic [A_W-1:0] st_mult_2,
  output logic [P_W-1:0] st_mult_pre,
  input  logic           st_rdy,
  input  logic [P_W-1:0] st_mult_next
);

  // Number of Booth digits and the width of the digit index.
  localparam int ND  = B_W / 2;
  localparam int K_W = (ND > 1) ? $clog2(ND) : 1;

  // Most negative multiplicand: the stage cannot negate it.
  localparam logic [A_W-1:0] A_MIN = {1'b1, {(A_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [P_W-1:0] acc;
  logic [K_W-1:0] k;

  // Multiplier with the implicit b[-1] = 0 appended below the LSB.
  logic [B_W:0]   b_ext;
  logic [2:0]     window;
  logic           accept;

  assign b_ext  = {b_q, 1'b0};

  // A start is taken only in IDLE and only when no abort is requested.
  assign accept = (state == IDLE) && start && !clr;

  // Select the 3-bit Booth window for the current digit index.
  always_comb begin
    window = 3'b000;
    for (int i = 0; i < ND; i++) begin
      if (k == K_W'(i)) begin
        window = b_ext[2*i +: 3];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clr overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (!st_rdy) begin
          state_nxt = IDLE;
        end else if (k == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ISSUE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (clr) begin
      state_nxt = IDLE;
    end
  end

  // Operand capture, accumulation, digit countdown, result and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      k       <= '0;
      product <= '0;
      a_ovf   <= 1'b0;
      err     <= 1'b0;
    end else if (!clr) begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            k     <= K_W'(ND - 1);
            err   <= 1'b0;
            a_ovf <= (a == A_MIN);
          end
        end
        CAPTURE: begin
          if (st_rdy) begin
            acc <= st_mult_next;
            if (k == '0) begin
              // product only changes on entry to DONE
              product <= st_mult_next;
            end else begin
              k <= k - 1'b1;
            end
          end else begin
            // stage did not answer: abandon the operation, keep acc as is
            err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status and stage-interface outputs; stage operands are held at 0 while idle.
  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    st_en       = (state == ISSUE) && !clr;
    st_mult_1   = 3'b000;
    st_mult_2   = '0;
    st_mult_pre = '0;
    if (state != IDLE) begin
      st_mult_1   = window;
      st_mult_2   = a_q;
      st_mult_pre = {acc[P_W-3:0], 2'b00};
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: table vectors, random operands against a plain a*b model,
// and hand-written sequences for busy-start, clr, mid-run reset and stage timeout.
// The external Booth stage is modelled here as a one-cycle registered unit.
module tb_booth_mult_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               clr;
  logic signed [11:0] a;
  logic signed [11:0] b;
  logic               busy;
  logic               done;
  logic [23:0]        product;
  logic               a_ovf;
  logic               err;
  logic               st_en;
  logic [2:0]         st_mult_1;
  logic [11:0]        st_mult_2;
  logic [23:0]        st_mult_pre;
  logic               st_rdy;
  logic [23:0]        st_mult_next;
  logic               force_nordy;

  int n_chk  = 0;
  int n_fail = 0;

  // results of the last do_op
  logic [23:0] r_p;
  int          r_lat;
  int          r_busy;
  int          r_ndone;
  logic        r_got;
  logic        r_ovf;
  logic        r_err;

  typedef struct {
    logic signed [11:0] a;
    logic signed [11:0] b;
    logic [23:0]        p;
  } vec_t;

  vec_t tbl[11];

  booth_mult_seq #(.A_W(12), .B_W(12), .P_W(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clr          (clr),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .a_ovf        (a_ovf),
    .err          (err),
    .st_en        (st_en),
    .st_mult_1    (st_mult_1),
    .st_mult_2    (st_mult_2),
    .st_mult_pre  (st_mult_pre),
    .st_rdy       (st_rdy),
    .st_mult_next (st_mult_next)
  );

  always #5 clk = ~clk;

  // External stage: pre + digit*m, negation wrapping in 12 bits like real hardware.
  function automatic logic [23:0] stage_fn(input logic [2:0] w, input logic [11:0] m,
                                           input logic [23:0] pre);
    logic signed [11:0] neg;
    logic signed [23:0] pe;
    logic signed [23:0] ne;
    neg = -$signed(m);
    pe  = $signed(m);
    ne  = neg;
    case (w)
      3'b001, 3'b010: return pre + pe;
      3'b011:         return pre + (pe <<< 1);
      3'b100:         return pre + (ne <<< 1);
      3'b101, 3'b110: return pre + ne;
      default:        return pre;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_rdy       <= 1'b0;
      st_mult_next <= '0;
    end else begin
      st_rdy <= st_en && !force_nordy;
      if (st_en) begin
        st_mult_next <= stage_fn(st_mult_1, st_mult_2, st_mult_pre);
      end
    end
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One operation from start to return-to-IDLE, bounded at 40 cycles.
  task automatic do_op(input logic [11:0] ai, input logic [11:0] bi);
    @(negedge clk);
    a = ai;
    b = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    r_busy  = busy ? 1 : 0;
    r_got   = 1'b0;
    r_lat   = 0;
    r_ndone = 0;
    r_p     = '0;
    r_ovf   = 1'b0;
    r_err   = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (busy) r_busy++;
      if (done) begin
        r_ndone++;
        if (!r_got) begin
          r_got = 1'b1;
          r_lat = i;
          r_p   = product;
          r_ovf = a_ovf;
          r_err = err;
        end
      end
      if (!busy) break;
    end
  endtask

  task automatic check_op(input string name, input logic [23:0] exp_p);
    chk({name, " done seen"}, {23'd0, r_got}, 24'd1);
    chk({name, " product"}, r_p, exp_p);
    chk({name, " latency"}, 24'(r_lat), 24'd12);
    chk({name, " busy cycles"}, 24'(r_busy), 24'd13);
    chk({name, " done pulses"}, 24'(r_ndone), 24'd1);
    chk({name, " err"}, {23'd0, r_err}, 24'd0);
  endtask

  // Global time bound so a stuck design still ends the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          ndone;
    int          lat;
    logic [23:0] p;
    logic [23:0] ep;
    int          ea;
    int          eb;

    tbl[0]  = '{12'sd3,     12'sd5,     24'd15};
    tbl[1]  = '{-12'sd7,    12'sd9,     24'hFFFFC1};
    tbl[2]  = '{12'sd2047,  12'h800,    24'hC00800};
    tbl[3]  = '{-12'sd2047, 12'h800,    24'h3FF800};
    tbl[4]  = '{12'sd100,   12'sd0,     24'd0};
    tbl[5]  = '{12'sd0,     -12'sd1,    24'd0};
    tbl[6]  = '{-12'sd1,    -12'sd1,    24'd1};
    tbl[7]  = '{12'sd2047,  12'sd2047,  24'd4190209};
    tbl[8]  = '{12'sd1,     12'h800,    24'hFFF800};
    tbl[9]  = '{-12'sd1,    12'h800,    24'd2048};
    tbl[10] = '{-12'sd1234, 12'sd567,   24'hF552E2};

    rst_n       = 1'b0;
    start       = 1'b0;
    clr         = 1'b0;
    a           = '0;
    b           = '0;
    force_nordy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {23'd0, busy}, 24'd0);
    chk("reset done", {23'd0, done}, 24'd0);
    chk("reset product", product, 24'd0);
    chk("reset a_ovf", {23'd0, a_ovf}, 24'd0);
    chk("reset err", {23'd0, err}, 24'd0);
    chk("reset st_en", {23'd0, st_en}, 24'd0);
    chk("reset st_mult_pre", st_mult_pre, 24'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].a, tbl[i].b);
      check_op($sformatf("vec%0d", i), tbl[i].p);
      chk($sformatf("vec%0d a_ovf", i), {23'd0, r_ovf}, 24'd0);
    end

    // random operands against plain integer multiplication
    for (int i = 0; i < 30; i++) begin
      ea = int'($signed(12'($urandom)));
      while (ea == -2048) ea = int'($signed(12'($urandom)));
      eb = int'($signed(12'($urandom)));
      ep = 24'(ea * eb);
      do_op(12'(ea), 12'(eb));
      chk($sformatf("rand%0d product (%0d*%0d)", i, ea, eb), r_p, ep);
      chk($sformatf("rand%0d latency", i), 24'(r_lat), 24'd12);
    end

    // start while busy (during CAPTURE of the third digit processed) is ignored
    @(negedge clk);
    a = 12'sd11;
    b = -12'sd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    lat   = 0;
    p     = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        lat = i;
        p   = product;
      end
      if (i == 5) begin
        a = 12'sd100;
        b = 12'sd100;
        start = 1'b1;
      end
      if (i == 6) start = 1'b0;
    end
    chk("busy-start product", p, 24'hFFFF71);
    chk("busy-start done pulses", 24'(ndone), 24'd1);
    chk("busy-start latency", 24'(lat), 24'd12);

    // clr mid-run: st_en drops at once, IDLE next edge, product retained, no done
    do_op(12'sd3, 12'sd5);
    check_op("pre-clr", 24'd15);
    @(negedge clk);
    a = 12'sd9;
    b = 12'sd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("clr st_en before", {23'd0, st_en}, 24'd1);
    clr = 1'b1;
    #1;
    chk("clr st_en immediate", {23'd0, st_en}, 24'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr busy", {23'd0, busy}, 24'd0);
    chk("clr product kept", product, 24'd15);
    ndone = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("clr no done", 24'(ndone), 24'd0);

    // start together with clr in IDLE: start dropped
    @(negedge clk);
    start = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    clr = 1'b0;
    chk("start+clr busy", {23'd0, busy}, 24'd0);

    // asynchronous reset mid-operation
    do_op(12'sd5, 12'sd5);
    check_op("pre-reset", 24'd25);
    @(negedge clk);
    a = 12'sd5;
    b = 12'sd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {23'd0, busy}, 24'd0);
    chk("midreset product", product, 24'd0);
    chk("midreset st_en", {23'd0, st_en}, 24'd0);
    ndone = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midreset no done", 24'(ndone), 24'd0);
    do_op(12'sd6, 12'sd7);
    check_op("after reset", 24'd42);

    // most negative multiplicand flags a_ovf
    do_op(12'h800, 12'sd1);
    chk("ovf done seen", {23'd0, r_got}, 24'd1);
    chk("ovf a_ovf", {23'd0, r_ovf}, 24'd1);

    // stage never reports ready: err set, back to IDLE, no done
    force_nordy = 1'b1;
    do_op(12'sd5, 12'sd5);
    chk("timeout done pulses", 24'(r_ndone), 24'd0);
    chk("timeout busy cycles", 24'(r_busy), 24'd2);
    chk("timeout err", {23'd0, err}, 24'd1);
    chk("timeout busy", {23'd0, busy}, 24'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("timeout err sticky", {23'd0, err}, 24'd1);
    force_nordy = 1'b0;
    do_op(12'sd2, -12'sd3);
    check_op("err cleared by start", 24'hFFFFFA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
